// File: rtl/rle_block_encoder_if.sv
// rle_block_encoder_if: coefficient stream in, (run, value) symbol stream out.
interface rle_block_encoder_if #(
  parameter int COEF_W = 8,
  parameter int RUN_W = 4
);
  logic s_valid;
  logic s_ready;
  logic [COEF_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [RUN_W-1:0] m_run;
  logic [COEF_W-1:0] m_value;
  logic m_zrl;
  logic m_eob;
  logic m_last;
  modport slave (
    input s_valid, s_data, m_ready,
    output s_ready, m_valid, m_run, m_value, m_zrl, m_eob, m_last
  );
  modport master (
    output s_valid, s_data, m_ready,
    input s_ready, m_valid, m_run, m_value, m_zrl, m_eob, m_last
  );
endinterface

// File: rtl/rle_block_encoder.sv
// rle_block_encoder: zero-run-length encoder emitting (run, value), ZRL and EOB symbols per block.
module rle_block_encoder #(
  parameter int COEF_W = 8,
  parameter int BLOCK_LEN = 64,
  parameter int MAX_RUN = 15,
  parameter int RUN_W = 4,
  parameter int CNT_W = 7
) (
  input logic clk,
  input logic rst,
  rle_block_encoder_if.slave io,
  output logic blk_done_o,
  output logic [CNT_W-1:0] blk_syms_o
);
  typedef enum logic [1:0] {ACCEPT, ZRL, EOB} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d, zrun_q, zrun_d, nsym_q, nsym_d, tot_q, tot_d, blk_syms_q;
  logic [COEF_W-1:0] hold_q, hold_d, value_q, value_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic hold_last_q, hold_last_d, valid_q, valid_d, zrl_q, zrl_d, eob_q, eob_d, last_q, last_d;
  logic done_q, load, load_ok, hs, last_pos, long_run, fin;
  assign load_ok = ~valid_q | io.m_ready;
  assign io.s_ready = ~rst & (state_q == ACCEPT) & load_ok;
  assign hs = io.s_valid & io.s_ready;
  assign last_pos = pos_q == CNT_W'(BLOCK_LEN - 1);
  assign long_run = zrun_q > CNT_W'(MAX_RUN);
  assign fin = valid_q & io.m_ready & last_q;
  assign io.m_valid = valid_q;
  assign io.m_run = run_q;
  assign io.m_value = value_q;
  assign io.m_zrl = zrl_q;
  assign io.m_eob = eob_q;
  assign io.m_last = last_q;
  assign blk_done_o = done_q;
  assign blk_syms_o = blk_syms_q;
  // The first ZRL of a long run goes out with the coefficient handshake, so each ZRL costs one stall.
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    zrun_d = zrun_q;
    hold_d = hold_q;
    hold_last_d = hold_last_q;
    load = 1'b0;
    run_d = run_q;
    value_d = value_q;
    zrl_d = zrl_q;
    eob_d = eob_q;
    last_d = last_q;
    if (hs) begin
      pos_d = last_pos ? '0 : pos_q + CNT_W'(1);
      if (io.s_data == '0) begin
        zrun_d = last_pos ? '0 : zrun_q + CNT_W'(1);
        state_d = last_pos ? EOB : ACCEPT;
      end else begin
        load = 1'b1;
        run_d = long_run ? RUN_W'(MAX_RUN) : zrun_q[RUN_W-1:0];
        value_d = long_run ? '0 : io.s_data;
        {zrl_d, eob_d, last_d} = {long_run, 1'b0, ~long_run & last_pos};
        zrun_d = long_run ? zrun_q - CNT_W'(MAX_RUN + 1) : '0;
        hold_d = io.s_data;
        hold_last_d = last_pos;
        state_d = long_run ? ZRL : ACCEPT;
      end
    end else if (state_q == ZRL && load_ok) begin
      load = 1'b1;
      run_d = long_run ? RUN_W'(MAX_RUN) : zrun_q[RUN_W-1:0];
      value_d = long_run ? '0 : hold_q;
      {zrl_d, eob_d, last_d} = {long_run, 1'b0, ~long_run & hold_last_q};
      zrun_d = long_run ? zrun_q - CNT_W'(MAX_RUN + 1) : '0;
      state_d = long_run ? ZRL : ACCEPT;
    end else if (state_q == EOB && load_ok) begin
      load = 1'b1;
      run_d = '0;
      value_d = '0;
      {zrl_d, eob_d, last_d} = 3'b011;
      state_d = ACCEPT;
    end
    valid_d = load | (valid_q & ~io.m_ready);
    nsym_d = load ? (last_d ? '0 : nsym_q + CNT_W'(1)) : nsym_q;
    tot_d = (load & last_d) ? nsym_q + CNT_W'(1) : tot_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCEPT;
      pos_q <= '0;
      zrun_q <= '0;
      nsym_q <= '0;
      tot_q <= '0;
      hold_q <= '0;
      hold_last_q <= 1'b0;
      valid_q <= 1'b0;
      run_q <= '0;
      value_q <= '0;
      zrl_q <= 1'b0;
      eob_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      blk_syms_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      zrun_q <= zrun_d;
      nsym_q <= nsym_d;
      tot_q <= tot_d;
      hold_q <= hold_d;
      hold_last_q <= hold_last_d;
      valid_q <= valid_d;
      run_q <= run_d;
      value_q <= value_d;
      zrl_q <= zrl_d;
      eob_q <= eob_d;
      last_q <= last_d;
      done_q <= fin;
      if (fin) blk_syms_q <= tot_q;
    end
  end
endmodule

// File: tb/tb_rle_block_encoder.sv
// tb_rle_block_encoder: two encoders (BLOCK_LEN 8 and 64) checked against a queue-based symbol model.
module tb_rle_block_encoder;
  typedef struct packed {
    logic [3:0] run;
    logic [7:0] val;
    logic zrl;
    logic eob;
    logic last;
  } sym_t;
  typedef logic [7:0] byte_q_t[$];
  typedef sym_t sym_q_t[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sv[2];
  logic [7:0] sd[2];
  logic mr[2];
  logic sr[2], mv[2], mz[2], me[2], ml[2], bd[2];
  logic [3:0] mrun[2];
  logic [7:0] mval[2];
  logic [6:0] bs[2];
  int rmode[2] = '{0, 0};
  int stalls[2] = '{0, 0};
  int cmp_n = 0;
  int err_n = 0;
  sym_t exp_q[2][$];
  int exp_n[2][$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    rle_block_encoder_if #(.COEF_W(8), .RUN_W(4)) bus ();
    assign bus.s_valid = sv[g];
    assign bus.s_data = sd[g];
    assign bus.m_ready = mr[g];
    assign sr[g] = bus.s_ready;
    assign mv[g] = bus.m_valid;
    assign mrun[g] = bus.m_run;
    assign mval[g] = bus.m_value;
    assign mz[g] = bus.m_zrl;
    assign me[g] = bus.m_eob;
    assign ml[g] = bus.m_last;
    rle_block_encoder #(.COEF_W(8), .BLOCK_LEN(g == 0 ? 8 : 64), .MAX_RUN(15), .RUN_W(4), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .io(bus), .blk_done_o(bd[g]), .blk_syms_o(bs[g])
    );
  end
  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    cmp_n++;
    if (got !== want) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  // Reference: scan the block, count zeros, split long runs into 16-zero ZRLs, EOB if it ends in zero.
  function automatic void encode(input byte_q_t blk, output sym_q_t s);
    int run = 0;
    s = {};
    foreach (blk[i]) begin
      if (blk[i] == 8'd0) run++;
      else begin
        while (run > 15) begin
          s.push_back('{4'd15, 8'd0, 1'b1, 1'b0, 1'b0});
          run -= 16;
        end
        s.push_back('{run[3:0], blk[i], 1'b0, 1'b0, 1'b0});
        run = 0;
      end
    end
    if (blk[blk.size()-1] == 8'd0) s.push_back('{4'd0, 8'd0, 1'b0, 1'b1, 1'b0});
    s[s.size()-1].last = 1'b1;
  endfunction
  task automatic push(int g, logic [7:0] c);
    sv[g] = 1'b1;
    sd[g] = c;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (sr[g]) break;
      stalls[g]++;
      if (n > 500) begin
        $display("FAIL push_timeout dut%0d: s_ready got 0 want 1", g);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    sv[g] = 1'b0;
  endtask
  task automatic send_block(int g, byte_q_t blk, bit chk_lat);
    sym_q_t s;
    encode(blk, s);
    foreach (s[i]) exp_q[g].push_back(s[i]);
    exp_n[g].push_back(s.size());
    foreach (blk[i]) begin
      push(g, blk[i]);
      if (chk_lat && i == 0) begin
        chk("latency_valid", mv[g], 1);
        chk("latency_value", mval[g], s[0].val);
      end
    end
  endtask
  task automatic settle(int g);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sr[g]) break;
      stalls[g]++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain(int g);
    int n = 0;
    while ((exp_q[g].size() != 0 || exp_n[g].size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset(int g);
    chk("rst_s_ready", sr[g], 0);
    chk("rst_m_valid", mv[g], 0);
    chk("rst_m_zrl", mz[g], 0);
    chk("rst_m_eob", me[g], 0);
    chk("rst_m_last", ml[g], 0);
    chk("rst_blk_done", bd[g], 0);
    chk("rst_m_run", mrun[g], 0);
    chk("rst_m_value", mval[g], 0);
    chk("rst_blk_syms", bs[g], 0);
  endtask
  initial begin
    foreach (mr[i]) mr[i] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++)
        mr[i] = rmode[i] == 0 ? 1'b1 : rmode[i] == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  // Single compare process: symbol order, stall stability and blk_done timing/count.
  initial begin
    sym_t held[2];
    sym_t cur;
    logic stall_prev[2] = '{1'b0, 1'b0};
    logic acc_last[2] = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          stall_prev[g] = 1'b0;
          acc_last[g] = 1'b0;
          continue;
        end
        cur = '{mrun[g], mval[g], mz[g], me[g], ml[g]};
        if (stall_prev[g]) chk("stall_stable", {mv[g], cur}, {1'b1, held[g]});
        if (acc_last[g] || bd[g]) chk("blk_done", bd[g], acc_last[g]);
        if (bd[g]) begin
          if (exp_n[g].size() == 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL blk_done_unexpected dut%0d: got pulse want none", g);
          end else chk("blk_syms", bs[g], exp_n[g].pop_front());
        end
        acc_last[g] = mv[g] & mr[g] & ml[g];
        if (mv[g] && mr[g]) begin
          if (exp_q[g].size() == 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL symbol_unexpected dut%0d: got %0h want none", g, cur);
          end else chk("symbol", cur, exp_q[g].pop_front());
        end
        stall_prev[g] = mv[g] & ~mr[g];
        held[g] = cur;
      end
    end
  end
  initial begin
    byte_q_t b;
    sym_q_t s;
    foreach (sv[i]) begin
      sv[i] = 1'b0;
      sd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    b = {8'd5, 8'd0, 8'd0, 8'hFD, 8'd0, 8'd0, 8'd0, 8'd0};
    encode(b, s);
    chk("model_a_size", s.size(), 3);
    chk("model_a_pair", s[1], {4'd2, 8'hFD, 3'b000});
    chk("model_a_eob", s[2], {4'd0, 8'd0, 3'b011});
    stalls[0] = 0;
    send_block(0, b, 1);
    settle(0);
    chk("stall_eob8", stalls[0], 1);
    drain(0);
    chk("blk_syms_a", bs[0], 3);
    b = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    stalls[0] = 0;
    send_block(0, b, 1);
    settle(0);
    chk("stall_dense", stalls[0], 0);
    drain(0);
    chk("blk_syms_b", bs[0], 8);
    b = {};
    repeat (40) b.push_back(8'd0);
    b.push_back(8'd9);
    repeat (23) b.push_back(8'd0);
    encode(b, s);
    chk("model_c_size", s.size(), 4);
    chk("model_c_zrl", s[1], {4'd15, 8'd0, 3'b100});
    chk("model_c_pair", s[2], {4'd8, 8'd9, 3'b000});
    stalls[1] = 0;
    send_block(1, b, 0);
    settle(1);
    chk("stall_zrl_eob", stalls[1], 3);
    drain(1);
    chk("blk_syms_c", bs[1], 4);
    b = {};
    repeat (64) b.push_back(8'd0);
    stalls[1] = 0;
    repeat (3) send_block(1, b, 0);
    settle(1);
    chk("stall_all_zero", stalls[1], 3);
    drain(1);
    chk("blk_syms_zero", bs[1], 1);
    for (int pass = 0; pass < 2; pass++) begin
      rmode = pass == 0 ? '{1, 1} : '{0, 0};
      for (int k = 0; k < 12; k++) begin
        int g = k % 2;
        b = {};
        for (int i = 0; i < (g == 1 ? 64 : 8); i++)
          b.push_back($urandom_range(0, g == 1 ? 7 : 3) == 0 ? 8'($urandom_range(1, 255)) : 8'd0);
        send_block(g, b, 0);
      end
      drain(0);
      drain(1);
    end
    rmode = '{0, 2};
    repeat (2) @(posedge clk);
    #1;
    repeat (20) push(1, 8'd0);
    push(1, 8'd7);
    chk("zrl_held_valid", mv[1], 1);
    chk("zrl_held_flag", mz[1], 1);
    chk("zrl_s_ready", sr[1], 0);
    rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    exp_n[0].delete();
    exp_n[1].delete();
    @(posedge clk);
    #1;
    check_reset(1);
    check_reset(0);
    rst = 1'b0;
    rmode = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    b = {8'd0, 8'd0, 8'd0, 8'd5};
    repeat (60) b.push_back(8'd0);
    send_block(1, b, 0);
    drain(1);
    chk("blk_syms_after_rst", bs[1], 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/rle_block_encoder.md
# rle_block_encoder

Sequential, parametrised zero-run-length encoder for quantised, zig-zag-ordered JPEG coefficients. It accepts one coefficient per cycle over a valid/ready stream and emits (run, value) symbols. Runs longer than MAX_RUN are split into ZRL symbols, and a block that ends in zeros gets an EOB symbol. It sits between the zig-zag reorder buffer and the Huffman symbol coder, replacing the fixed 8-coefficient combinational run packer with a block-length-agnostic, back-pressure-aware stage.

## Interface
- COEF_W, 8, coefficient width (two's complement; zero test is all bits zero)
- BLOCK_LEN, 64, coefficients per block (≥2)
- MAX_RUN, 15, largest run carried by one symbol; a ZRL represents MAX_RUN+1 zeros
- RUN_W, 4, width of m_run (must hold MAX_RUN)
- CNT_W, 7, width of position/symbol counters (must hold BLOCK_LEN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input coefficient valid
- s_ready  out  1  encoder can accept a coefficient
- s_data  in  COEF_W  coefficient
- m_valid  out  1  output symbol valid
- m_ready  in  1  downstream accepts symbol
- m_run  out  RUN_W  zeros preceding m_value
- m_value  out  COEF_W  nonzero coefficient; 0 for ZRL/EOB
- m_zrl  out  1  symbol is ZRL (m_run=MAX_RUN, m_value=0)
- m_eob  out  1  symbol is EOB (m_run=0, m_value=0)
- m_last  out  1  final symbol of the current block
- blk_done  out  1  one-cycle pulse when the final symbol of a block is accepted downstream
- blk_syms  out  CNT_W  symbols emitted for the last completed block; valid while blk_done=1, held until the next block completes

## Operation
- Counters: pos (0..BLOCK_LEN-1, coefficient index in block), zrun (pending zeros), nsym (symbols in current block).
- Single-entry output register; the m_* fields change only when loaded.
- FSM states: ACCEPT, ZRL, EOB.
- ACCEPT: on a handshake (s_valid & s_ready):
  - Zero coefficient, not last: zrun += 1, no symbol.
  - Zero coefficient, last (pos=BLOCK_LEN-1): go to EOB.
  - Nonzero, zrun ≤ MAX_RUN: load pair (run=zrun, value=s_data); zrun := 0. m_last=1 if pos=BLOCK_LEN-1.
  - Nonzero, zrun > MAX_RUN: latch s_data and last flag into hold regs; go to ZRL.
- ZRL: s_ready=0. Each output load emits one ZRL and subtracts MAX_RUN+1 from zrun. When zrun ≤ MAX_RUN, load the held pair (with held m_last) and return to ACCEPT.
- EOB: s_ready=0. Load EOB with m_last=1 and return to ACCEPT. Pending zrun is discarded; trailing ZRLs are never emitted.
- A block whose last coefficient is nonzero produces no EOB. An all-zero block produces exactly one EOB (blk_syms=1).
- End of block (final symbol accepted): pos, zrun, nsym := 0; blk_syms := nsym+1; blk_done=1.
- Signed values pass through unmodified.

## Timing
- Reset: s_ready=0 while rst=1. m_valid, m_zrl, m_eob, m_last, blk_done=0. m_run, m_value, blk_syms=0. State ACCEPT, counters 0.
- Reset mid-block discards the partial block and any held symbol; no blk_done.
- Output register is loadable when m_valid=0 or m_ready=1 (same-cycle drain and refill).
- s_ready = ~rst & state==ACCEPT & (~m_valid | m_ready). Zero coefficients never need the output slot but obey the same s_ready.
- Latency: coefficient handshake at cycle N gives its symbol m_valid at N+1.
- Throughput with m_ready=1 is 1 coefficient/cycle. Each ZRL or EOB costs one extra cycle of s_ready=0.
- m_* must stay stable while m_valid=1 and m_ready=0.
- blk_done is asserted in the cycle after the handshake of the m_last symbol.

## Test plan
- BLOCK_LEN=8, input 5,0,0,-3,0,0,0,0, m_ready=1 -> (0,5),(2,-3),EOB with m_last on EOB; blk_syms=3.
- BLOCK_LEN=8, input 1,2,3,4,5,6,7,8 -> eight pairs of run 0, m_last on (0,8), no EOB; blk_syms=8; s_ready high throughout.
- BLOCK_LEN=64, 40 zeros then 9 then 23 zeros -> ZRL, ZRL, (8,9), EOB; s_ready low for 2 cycles after 9 and 1 cycle for EOB; blk_syms=4.
- BLOCK_LEN=64, all zeros -> single EOB with m_last=1; blk_syms=1. Repeat back-to-back blocks -> one EOB each, counters restart.
- Random m_ready toggling (50%) on a random block -> symbol stream identical to the m_ready=1 run; m_* stable during stalls; no coefficient lost.
- rst asserted in ZRL state mid-block -> next cycle all outputs 0. The next full block encodes correctly with no leftover zrun.
